// File: rtl/digit_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit display.
// It holds a tear-free shadow of the digit bus and applies leading-zero and per-digit blanking.
module digit_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_W     = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits_in,
    input  logic                            load,
    input  logic [NUM_DIGITS-1:0]           blank_mask,
    input  logic                            lz_suppress,
    output logic [DIGIT_W-1:0]              digit_out,
    output logic [NUM_DIGITS-1:0]           an,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]              r_presc;
    logic [IDX_W-1:0]              r_idx;
    logic [NUM_DIGITS*DIGIT_W-1:0] r_shadow;
    logic                          r_wrap;
    logic [DIGIT_W-1:0]            r_digit_out;
    logic [NUM_DIGITS-1:0]         r_an;
    logic [IDX_W-1:0]              r_digit_idx;
    logic                          r_frame_done;

    logic                          w_tick;
    logic                          w_last_idx;
    logic [DIGIT_W-1:0]            w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]         w_upper_zero;
    logic                          w_zero_run;
    logic [NUM_DIGITS-1:0]         w_blank;
    logic [DIGIT_W-1:0]            w_cur_digit;
    logic                          w_cur_blank;
    logic [NUM_DIGITS-1:0]         w_an_sel;

    assign w_tick     = (r_presc == CNT_W'(REFRESH_DIV - 1));
    assign w_last_idx = (r_idx == IDX_W'(NUM_DIGITS - 1));

    // Digit i is a leading zero when it and every more significant digit are zero.
    always_comb begin
        w_zero_run   = 1'b1;
        w_upper_zero = '0;
        w_blank      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit[i] = r_shadow[i*DIGIT_W +: DIGIT_W];
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run      = w_zero_run & (w_digit[i] == '0);
            w_upper_zero[i] = w_zero_run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_blank[i] = blank_mask[i] | (lz_suppress & (i != 0) & w_upper_zero[i]);
        end
    end

    assign w_cur_digit = w_digit[r_idx];
    assign w_cur_blank = w_blank[r_idx];
    assign w_an_sel    = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the shadow is a plain register and is cleared like the rest of the state,
            // so a reset display shows "0" instead of whatever was on the bus.
            r_presc      <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_wrap       <= 1'b0;
            r_digit_out  <= '0;
            r_an         <= '1;
            r_digit_idx  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
            if (w_tick) begin
                r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
            end
            if (load) begin
                r_shadow <= digits_in;
            end
            // frame_done is delayed one stage so it lines up with digit 0 on the outputs.
            r_wrap       <= w_tick & w_last_idx;
            r_frame_done <= r_wrap;
            r_digit_idx  <= r_idx;
            r_digit_out  <= w_cur_blank ? '0 : w_cur_digit;
            r_an         <= w_cur_blank ? '1 : w_an_sel;
        end
    end

    assign digit_out  = r_digit_out;
    assign an         = r_an;
    assign digit_idx  = r_digit_idx;
    assign frame_done = r_frame_done;

endmodule
